// File: rtl/ed_pkg.sv
// Shared types and defaults for the sliding-window energy detector.
// State encoding and default widths live here.
package ed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } ed_state_e;

  localparam int ED_DATA_W  = 32;
  localparam int ED_MAX_WIN = 1024;

endpackage

// File: rtl/ed_sliding_window_if.sv
// Sample stream in, tagged sample + energy stream out.
// master drives samples and out_ready, slave is the detector.
interface ed_sliding_window_if
  import ed_pkg::*;
#(
  parameter int DATA_W = ED_DATA_W,
  parameter int ACC_W  = ED_DATA_W + $clog2(ED_MAX_WIN) + 1
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [ACC_W-1:0]  out_energy;
  logic              out_full;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_energy,
    input  out_full,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_energy,
    output out_full,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/ed_delay_ram.sv
// Single-port read-first synchronous RAM holding the window history.
// Contents are not reset; the fill count keeps stale words out.
module ed_delay_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/ed_sliding_window.sv
// Sliding-window energy detector with hysteresis, two-stage pipeline.
// Stage 1 swaps the oldest sample out of RAM, stage 2 updates energy.
module ed_sliding_window
  import ed_pkg::*;
#(
  parameter int DATA_W  = ED_DATA_W,
  parameter int MAX_WIN = ED_MAX_WIN,
  parameter int ACC_W   = DATA_W + $clog2(MAX_WIN) + 1
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        restart,
  input  logic [$clog2(MAX_WIN):0]    window_size,
  input  logic [ACC_W-1:0]            th_hi,
  input  logic [ACC_W-1:0]            th_lo,
  ed_sliding_window_if.slave          bus
);

  localparam int AW = $clog2(MAX_WIN);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] W_MAX = (AW+1)'(MAX_WIN);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sub;
    logic              full;
  } s1_t;

  ed_state_e         state;
  logic [AW:0]       win;
  logic [AW:0]       win_sel;
  logic [AW:0]       wlast;
  logic [AW:0]       cnt;
  logic [AW-1:0]     ptr;
  logic              last;
  logic [ACC_W-1:0]  energy;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  acc_next;
  logic              det;
  logic              det_next;
  s1_t               s1;
  logic              s1_valid;
  logic [DATA_W-1:0] old_data;
  logic              stall;
  logic              accept;
  logic [DATA_W-1:0] out_data;
  logic [ACC_W-1:0]  out_energy;
  logic              out_full;
  logic              out_valid;

  assign stall        = out_valid & ~bus.out_ready;
  assign bus.in_ready = enable & (state != IDLE) & ~restart & ~stall;
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.out_data   = out_data;
  assign bus.out_energy = out_energy;
  assign bus.out_full   = out_full;
  assign bus.out_valid  = out_valid;

  assign wlast = win - ONE;
  assign last  = ({1'b0, ptr} == wlast);

  always_comb begin
    win_sel = window_size;
    if (window_size == '0)
      win_sel = ONE;
    else if (window_size > W_MAX)
      win_sel = W_MAX;
  end

  // The oldest sample is only subtracted once the window has wrapped.
  always_comb begin
    acc_sum  = energy + ACC_W'(s1.data);
    acc_next = acc_sum - (s1.sub ? ACC_W'(old_data) : '0);
    det_next = 1'b0;
    if (s1.full)
      det_next = det ? (acc_next >= th_lo) : (acc_next >= th_hi);
  end

  ed_delay_ram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clock),
    .en    (accept),
    .we    (accept),
    .addr  (ptr),
    .wdata (bus.in_data),
    .rdata (old_data)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win        <= ONE;
      cnt        <= '0;
      ptr        <= '0;
      energy     <= '0;
      det        <= 1'b0;
      s1         <= '0;
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_energy <= '0;
      out_full   <= 1'b0;
    end else if (restart) begin
      state     <= enable ? FILL : IDLE;
      win       <= win_sel;
      cnt       <= '0;
      ptr       <= '0;
      energy    <= '0;
      det       <= 1'b0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_full  <= 1'b0;
    end else begin
      if (state == IDLE && enable) begin
        state <= FILL;
        win   <= win_sel;
      end
      if (accept) begin
        s1.data <= bus.in_data;
        s1.sub  <= (state == RUN);
        s1.full <= (state == RUN) || (cnt == wlast);
        ptr     <= last ? '0 : ptr + AW'(1);
        if (state == FILL) begin
          cnt <= cnt + ONE;
          if (cnt == wlast) state <= RUN;
        end
      end
      // Everything downstream of the RAM freezes while the output is held.
      if (!stall) begin
        s1_valid  <= accept;
        out_valid <= s1_valid;
        if (s1_valid) begin
          energy     <= acc_next;
          det        <= det_next;
          out_data   <= {det_next, s1.data[DATA_W-2:0]};
          out_energy <= acc_next;
          out_full   <= s1.full;
        end
      end
    end
  end

endmodule

// File: tb/tb_ed_sliding_window.sv
// Bench for ed_sliding_window: window-sum scoreboard plus literal vectors.
// Small geometry (16-bit samples, 16-deep window) keeps runs short.
module tb_ed_sliding_window;

  localparam int DW = 16;
  localparam int MW = 16;
  localparam int AW = 4;
  localparam int AC = DW + AW + 1;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          restart = 1'b0;
  logic [AW:0]   window_size = '0;
  logic [AC-1:0] th_hi = '0;
  logic [AC-1:0] th_lo = '0;

  ed_sliding_window_if #(.DATA_W(DW), .ACC_W(AC)) bus ();

  ed_sliding_window #(
    .DATA_W  (DW),
    .MAX_WIN (MW),
    .ACC_W   (AC)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .enable      (enable),
    .restart     (restart),
    .window_size (window_size),
    .th_hi       (th_hi),
    .th_lo       (th_lo),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     chk_lat = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    longint data;
    longint energy;
    bit     full;
    longint cyc;
  } exp_t;

  exp_t   expq[$];
  exp_t   cur;
  longint hist[$];
  int     mw = 1;
  int     mk = 0;
  bit     m_idle = 1'b1;
  bit     mdet = 1'b0;
  bit     seen = 1'b0;
  longint log_e[$];
  bit     log_d[$];
  bit     log_f[$];

  function automatic int clampw(input int ws);
    if (ws == 0) return 1;
    if (ws > MW) return MW;
    return ws;
  endfunction

  task automatic model_clear(input int w);
    hist.delete();
    expq.delete();
    mk   = 0;
    mdet = 1'b0;
    mw   = w;
    seen = 1'b0;
  endtask

  task automatic model_accept(input longint s);
    longint e;
    bit     full;
    exp_t   x;
    e = 0;
    hist.push_back(s);
    if (hist.size() > mw) void'(hist.pop_front());
    foreach (hist[i]) e += hist[i];
    full = (mk >= mw - 1);
    mk++;
    if (!full) mdet = 1'b0;
    else if (mdet) mdet = (e >= longint'(th_lo));
    else mdet = (e >= longint'(th_hi));
    x.data   = (longint'(mdet) << (DW-1)) | (s & ((longint'(1) << (DW-1)) - 1));
    x.energy = e;
    x.full   = full;
    x.cyc    = cyc;
    expq.push_back(x);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!rst_n) begin
      model_clear(1);
      m_idle = 1'b1;
    end else begin
      if (bus.out_valid && expq.size() > 0 && !seen) begin
        seen = 1'b1;
        if (chk_lat) check("latency", cyc - expq[0].cyc, 2);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          cur = expq.pop_front();
          check("out_data", longint'(bus.out_data), cur.data);
          check("out_energy", longint'(bus.out_energy), cur.energy);
          check("out_full", longint'(bus.out_full), longint'(cur.full));
          log_e.push_back(longint'(bus.out_energy));
          log_d.push_back(bus.out_data[DW-1]);
          log_f.push_back(bus.out_full);
          seen = 1'b0;
        end
      end
      if (bus.out_valid && !bus.out_ready)
        check("in_ready_stall", longint'(bus.in_ready), 0);
      if (m_idle)
        check("in_ready_idle", longint'(bus.in_ready), 0);
      if (restart) begin
        check("in_ready_restart", longint'(bus.in_ready), 0);
        model_clear(clampw(int'(window_size)));
        m_idle = !enable;
      end else if (m_idle && enable) begin
        m_idle = 1'b0;
        mw = clampw(int'(window_size));
      end
      if (bus.in_valid && bus.in_ready) model_accept(longint'(bus.in_data));
    end
  end

  task automatic send(input longint v);
    int n;
    n = 0;
    bus.in_data  = DW'(v);
    bus.in_valid = 1'b1;
    @(negedge clock);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) check("send_timeout", 1, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_restart(input int ws);
    window_size = (AW+1)'(ws);
    restart = 1'b1;
    @(posedge clock);
    #1;
    restart = 1'b0;
  endtask

  int e1[8] = '{10, 20, 30, 40, 40, 40, 40, 40};
  int d1[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
  int e2[6] = '{60, 120, 90, 60, 40, 20};
  int d2[6] = '{0, 1, 1, 1, 0, 0};
  int e5[3] = '{7, 100, 3};
  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    th_hi = AC'(40);
    th_lo = AC'(40);
    rst_n = 1'b0;
    idle(2);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_out_energy", longint'(bus.out_energy), 0);
    check("rst_out_full", longint'(bus.out_full), 0);
    check("rst_in_ready", longint'(bus.in_ready), 0);

    rst_n = 1'b1;
    window_size = 5'd4;
    enable = 1'b1;
    chk_lat = 1'b1;
    idle(1);
    base = log_e.size();
    for (int i = 0; i < 8; i++) send(10);
    bus.in_valid = 1'b0;
    idle(4);
    check("t1_count", log_e.size() - base, 8);
    if (log_e.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t1_energy", log_e[base+i], e1[i]);
        check("t1_det", longint'(log_d[base+i]), d1[i]);
        check("t1_full", longint'(log_f[base+i]), d1[i]);
      end
    end

    th_hi = AC'(100);
    th_lo = AC'(50);
    pulse_restart(2);
    base = log_e.size();
    send(60); send(60); send(30); send(30); send(10); send(10);
    bus.in_valid = 1'b0;
    idle(4);
    check("t2_count", log_e.size() - base, 6);
    if (log_e.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t2_energy", log_e[base+i], e2[i]);
        check("t2_det", longint'(log_d[base+i]), d2[i]);
      end
    end

    th_hi = AC'(300);
    th_lo = AC'(200);
    chk_lat = 1'b0;
    pulse_restart(8);
    base = log_e.size();
    fork
      begin
        for (int i = 0; i < 20; i++) send(i * 7 + 3);
        bus.in_valid = 1'b0;
      end
      begin
        idle(8);
        bus.out_ready = 1'b0;
        idle(5);
        bus.out_ready = 1'b1;
      end
    join
    idle(6);
    check("t3_count", log_e.size() - base, 20);

    th_hi = AC'(40);
    th_lo = AC'(40);
    chk_lat = 1'b1;
    pulse_restart(4);
    for (int i = 0; i < 6; i++) send(5 + i);
    bus.in_data  = DW'(77);
    bus.in_valid = 1'b1;
    restart = 1'b1;
    idle(1);
    restart = 1'b0;
    bus.in_data = DW'(9);
    base = log_e.size();
    @(negedge clock);
    check("t4_out_valid_after_restart", longint'(bus.out_valid), 0);
    check("t4_in_ready_fill", longint'(bus.in_ready), 1);
    idle(1);
    bus.in_valid = 1'b0;
    idle(4);
    check("t4_count", log_e.size() - base, 1);
    if (log_e.size() >= base + 1) begin
      check("t4_energy", log_e[base], 9);
      check("t4_full", longint'(log_f[base]), 0);
    end

    th_hi = AC'(1000);
    th_lo = AC'(1000);
    pulse_restart(0);
    base = log_e.size();
    send(7); send(100); send(3);
    bus.in_valid = 1'b0;
    idle(4);
    check("t5_count", log_e.size() - base, 3);
    if (log_e.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t5_energy", log_e[base+i], e5[i]);
        check("t5_full", longint'(log_f[base+i]), 1);
      end
    end

    pulse_restart(MW + 5);
    base = log_e.size();
    for (int i = 0; i < 40; i++) send(65535);
    bus.in_valid = 1'b0;
    idle(4);
    check("t5b_count", log_e.size() - base, 40);
    if (log_e.size() >= base + 40) begin
      check("t5b_first", log_e[base], 65535);
      check("t5b_full14", longint'(log_f[base+14]), 0);
      check("t5b_full15", longint'(log_f[base+15]), 1);
      check("t5b_e15", log_e[base+15], 1048560);
      check("t5b_last", log_e[base+39], 1048560);
    end

    pulse_restart(2);
    bus.out_ready = 1'b0;
    send(1);
    send(2);
    bus.in_valid = 1'b0;
    idle(2);
    @(negedge clock);
    check("t6_out_valid_held", longint'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", longint'(bus.out_valid), 0);
    check("t6_out_data", longint'(bus.out_data), 0);
    check("t6_out_energy", longint'(bus.out_energy), 0);
    check("t6_out_full", longint'(bus.out_full), 0);
    check("t6_in_ready", longint'(bus.in_ready), 0);
    @(negedge clock);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clock);
    check("t6_idle_after_release", longint'(bus.in_ready), 0);
    @(negedge clock);
    check("t6_fill_after_idle", longint'(bus.in_ready), 1);
    idle(2);
    check("scoreboard_drain", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ed_sliding_window.md
ED_SLIDING_WINDOW -- requirements
Module: ed_sliding_window

Interface
REQ-001 Parameter DATA_W, default 32, sample width (squared magnitude, unsigned).
REQ-002 Parameter MAX_WIN, default 1024, maximum window length (power of two); AW = log2(MAX_WIN).
REQ-003 Parameter ACC_W, default DATA_W+AW+1, energy accumulator width.
REQ-004 Ports: clock in 1 rising-edge clock; rst_n in 1 asynchronous active-low reset; enable in 1 run gate; restart in 1 sync clear pulse.
REQ-005 Ports: window_size in AW+1 window length W; th_hi in ACC_W assert threshold; th_lo in ACC_W release threshold.
REQ-006 Ports: in_data in DATA_W sample; in_valid in 1; in_ready out 1.
REQ-007 Ports: out_data out DATA_W {det, sample[DATA_W-2:0]}; out_energy out ACC_W; out_full out 1 window filled; out_valid out 1; out_ready in 1.

Function
REQ-008 States SHALL be IDLE, FILL, RUN; IDLE->FILL when enable=1; FILL->RUN on acceptance of sample W-1 (0-based since restart); RUN holds until restart or reset.
REQ-009 window_size SHALL be latched on IDLE->FILL and on restart; 0 treated as 1, values >MAX_WIN clamped to MAX_WIN; changes at other times ignored.
REQ-010 Acceptance SHALL occur when in_valid and in_ready; in_ready = enable and not IDLE and not restart and not (out_valid and not out_ready).
REQ-011 Pipeline SHALL be 2 stages: stage 1 reads oldest sample at ptr (read-first) and writes in_data at ptr; stage 2 updates energy and loads output register.
REQ-012 Latency SHALL be 2 cycles accept->out_valid with no back-pressure; all stages freeze while out_valid=1 and out_ready=0; no sample lost or duplicated.
REQ-013 ptr SHALL increment per accepted sample and wrap to 0 after W-1.
REQ-014 Energy after sample k SHALL be sum of last min(k+1,W) samples: add new, subtract oldest only when k>=W.
REQ-015 Accumulator SHALL never overflow (ACC_W covers MAX_WIN full-scale samples); subtraction unsigned, result never negative.
REQ-016 det update: if det=0, det=1 when energy>=th_hi; if det=1, det=0 when energy<th_lo; th_lo=th_hi gives fixed threshold.
REQ-017 During FILL det SHALL be forced 0 and out_full=0; samples still emitted in order.
REQ-018 out_energy SHALL be the energy including the emitted sample; out_data MSB = det for that sample.
REQ-019 restart SHALL, next cycle: clear energy, ptr, fill count, det, discard in-flight pipeline data, drop out_valid, enter FILL if enable=1 else IDLE; restart beats a simultaneous accept.
REQ-020 enable=0 SHALL only deassert in_ready; state, energy, det and pending output retained; out_valid/out_ready handshake continues.
REQ-021 Stale RAM contents SHALL never enter the energy (guarded by k>=W).

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, in_ready 0, out_valid 0, out_data 0, out_energy 0, out_full 0, det 0, ptr 0, fill count 0, latched W = 1.
REQ-023 RAM contents SHALL not require reset; release of rst_n synchronised externally.

Structure
REQ-024 Shared package ed_pkg SHALL hold state encoding (IDLE/FILL/RUN) and default DATA_W/MAX_WIN constants.
REQ-025 Sub-module ed_delay_ram SHALL implement the MAX_WIN x DATA_W single-port read-first synchronous RAM with enable.
REQ-026 No vendor FIFO/accumulator cores; target 120-400 lines RTL.

Verification
REQ-027 W=4, th_hi=th_lo=40, inputs 10 x8 -> energies 10,20,30,40,40..; out_full from 4th; det=1 from 4th; latency 2.
REQ-028 Hysteresis W=2, th_hi=100, th_lo=50, inputs 60,60,30,30,10,10 -> energy 60,120,90,60,40,20; det 0,1,1,1,0,0.
REQ-029 Back-pressure: out_ready low 5 cycles mid-stream W=8 -> in_ready low after output register full, output sequence identical to unstalled run.
REQ-030 restart after 6 samples W=4, same cycle as in_valid -> sample dropped, out_valid 0 next cycle, next output energy = first new sample, out_full 0.
REQ-031 Boundaries: window_size=0 -> W=1, energy=sample; window_size=MAX_WIN+5 -> clamp, wrap exercised with all-ones samples, no overflow.
REQ-032 rst_n asserted mid-RUN with out_valid=1 -> all outputs 0 immediately, IDLE after release.
